// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_rx_pkg;

    localparam int unsigned DATA_W       = 8;
    localparam int unsigned PRESCALE_W   = 6;
    localparam int unsigned BIT_CNT_W    = 4;
    localparam int unsigned START_IDX    = 0;
    localparam int unsigned PAR_IDX      = DATA_W + 1;
    localparam int unsigned MIN_PRESCALE = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } rx_state_e;

    // Counter commands from the FSM; clr wins over load_one, which wins over cnt_en.
    typedef struct packed {
        logic cnt_en;
        logic clr;
        logic load_one;
        logic cap_en;
    } cnt_ctrl_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Bundle between the RX frame controller and the line/datapath side.
interface uart_rx_ctrl_if
    import uart_rx_pkg::*;
#(
    parameter int unsigned PSW = PRESCALE_W
) ();

    logic                 RX_IN;
    logic                 PAR_EN;
    logic [PSW-1:0]       Prescale;
    logic                 Sampled_bit;
    logic                 Par_Err;
    logic [PSW-1:0]       Edge_Cnt;
    logic [BIT_CNT_W-1:0] Bit_Cnt;
    logic                 Bit_Available;
    logic                 Strt_Chk_En;
    logic                 Deser_En;
    logic                 Par_Chk_En;
    logic                 Stp_Chk_En;
    logic                 Data_Valid;
    logic                 Frame_Err;

    modport master (
        input  RX_IN, PAR_EN, Prescale, Sampled_bit, Par_Err,
        output Edge_Cnt, Bit_Cnt, Bit_Available, Strt_Chk_En, Deser_En,
               Par_Chk_En, Stp_Chk_En, Data_Valid, Frame_Err
    );

    modport slave (
        output RX_IN, PAR_EN, Prescale, Sampled_bit, Par_Err,
        input  Edge_Cnt, Bit_Cnt, Bit_Available, Strt_Chk_En, Deser_En,
               Par_Chk_En, Stp_Chk_En, Data_Valid, Frame_Err
    );

endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter, bit counter and captured prescale for the RX frame.
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int unsigned PSW = PRESCALE_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  cnt_ctrl_t            ctrl,
    input  logic [PSW-1:0]       prescale,
    output logic [PSW-1:0]       edge_cnt,
    output logic [BIT_CNT_W-1:0] bit_cnt,
    output logic                 last_edge_c
);

    logic [PSW-1:0]       edge_cnt_q, edge_cnt_d;
    logic [PSW-1:0]       prescale_q, prescale_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q,  bit_cnt_d;

    assign last_edge_c = (edge_cnt_q == (prescale_q - PSW'(1)));

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        prescale_d = prescale_q;

        if (ctrl.cap_en) begin
            prescale_d = prescale;
        end

        if (ctrl.clr) begin
            edge_cnt_d = '0;
            bit_cnt_d  = BIT_CNT_W'(START_IDX);
        end else if (ctrl.load_one) begin
            // Back-to-back frame: the DONE cycle already counts as the first start-bit clock.
            edge_cnt_d = PSW'(1);
            bit_cnt_d  = BIT_CNT_W'(START_IDX);
        end else if (ctrl.cnt_en) begin
            if (last_edge_c) begin
                edge_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
            end else begin
                edge_cnt_d = edge_cnt_q + PSW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            prescale_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            prescale_q <= prescale_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: start detect, per-bit check enables and frame qualification.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DW  = DATA_W,
    parameter int unsigned PSW = PRESCALE_W
) (
    input  logic           CLK,
    input  logic           RST,
    uart_rx_ctrl_if.master bus
);

    // Parity index tracks DW when the frame width is overridden.
    localparam int unsigned PAR_BIT = PAR_IDX + DW - DATA_W;

    rx_state_e            state_q, state_d;
    cnt_ctrl_t            cnt_ctrl;
    logic [PSW-1:0]       edge_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 last_edge;
    logic                 bit_avail;
    logic                 prescale_ok;

    logic strt_chk_en_q, strt_chk_en_d;
    logic deser_en_q,    deser_en_d;
    logic par_chk_en_q,  par_chk_en_d;
    logic stp_chk_en_q,  stp_chk_en_d;
    logic data_valid_q,  data_valid_d;
    logic frame_err_q,   frame_err_d;

    uart_rx_edge_bit_cnt #(.PSW(PSW)) u_cnt (
        .clk         (CLK),
        .rst         (RST),
        .ctrl        (cnt_ctrl),
        .prescale    (bus.Prescale),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .last_edge_c (last_edge)
    );

    assign prescale_ok = (bus.Prescale >= PSW'(MIN_PRESCALE));
    assign bit_avail   = last_edge &&
                         (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP});

    always_comb begin
        state_d      = state_q;
        cnt_ctrl     = '0;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_ctrl.clr = 1'b1;
                if (!bus.RX_IN && prescale_ok) begin
                    state_d         = ST_START;
                    cnt_ctrl.cap_en = 1'b1;
                end
            end
            ST_START: begin
                cnt_ctrl.cnt_en = 1'b1;
                if (bit_avail) begin
                    if (bus.Sampled_bit) begin
                        state_d      = ST_IDLE;
                        cnt_ctrl.clr = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                cnt_ctrl.cnt_en = 1'b1;
                if (bit_avail && (bit_cnt == BIT_CNT_W'(PAR_BIT - 1))) begin
                    state_d = bus.PAR_EN ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                cnt_ctrl.cnt_en = 1'b1;
                if (bit_avail) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                cnt_ctrl.cnt_en = 1'b1;
                if (bit_avail) begin
                    // Par_Err is already registered by the checker at this point.
                    state_d      = ST_DONE;
                    cnt_ctrl.clr = 1'b1;
                    data_valid_d = bus.Sampled_bit && (!bus.PAR_EN || !bus.Par_Err);
                    frame_err_d  = !bus.Sampled_bit;
                end
            end
            ST_DONE: begin
                if (!bus.RX_IN && prescale_ok) begin
                    state_d           = ST_START;
                    cnt_ctrl.load_one = 1'b1;
                    cnt_ctrl.cap_en   = 1'b1;
                end else begin
                    state_d      = ST_IDLE;
                    cnt_ctrl.clr = 1'b1;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                cnt_ctrl.clr = 1'b1;
            end
        endcase

        strt_chk_en_d = (state_d == ST_START);
        deser_en_d    = (state_d == ST_DATA);
        par_chk_en_d  = (state_d == ST_PARITY);
        stp_chk_en_d  = (state_d == ST_STOP);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            strt_chk_en_q <= 1'b0;
            deser_en_q    <= 1'b0;
            par_chk_en_q  <= 1'b0;
            stp_chk_en_q  <= 1'b0;
            data_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            strt_chk_en_q <= strt_chk_en_d;
            deser_en_q    <= deser_en_d;
            par_chk_en_q  <= par_chk_en_d;
            stp_chk_en_q  <= stp_chk_en_d;
            data_valid_q  <= data_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign bus.Edge_Cnt      = edge_cnt;
    assign bus.Bit_Cnt       = bit_cnt;
    assign bus.Bit_Available = bit_avail;
    assign bus.Strt_Chk_En   = strt_chk_en_q;
    assign bus.Deser_En      = deser_en_q;
    assign bus.Par_Chk_En    = par_chk_en_q;
    assign bus.Stp_Chk_En    = stp_chk_en_q;
    assign bus.Data_Valid    = data_valid_q;
    assign bus.Frame_Err     = frame_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frame table, corner sequences and random frames vs. a timeline model.
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;

    localparam int unsigned TB_PSW = 6;
    localparam int unsigned N_VEC  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_ctrl_if #(.PSW(TB_PSW)) bus ();

    uart_rx_ctrl #(.DW(DATA_W), .PSW(TB_PSW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.master)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         prescale;
        bit         par_en;
        logic [7:0] data;
        bit         stop_b;
        bit         perr;
        int         exp_cycle;
        bit         exp_dv;
        bit         exp_fe;
        int         exp_max_bit;
        bit         exp_par_win;
    } frame_vec_t;

    frame_vec_t tbl [N_VEC];

    int ev, ev2, mb, dc;
    bit dv, fe, pw;

    function automatic logic [31:0] dut_vec();
        return 32'({bus.Edge_Cnt, bus.Bit_Cnt, bus.Bit_Available, bus.Strt_Chk_En,
                    bus.Deser_En, bus.Par_Chk_En, bus.Stp_Chk_En, bus.Data_Valid,
                    bus.Frame_Err});
    endfunction

    function automatic logic [31:0] exp_vec(input int e, input int b, input bit ba,
                                            input bit st, input bit de, input bit pa,
                                            input bit sp, input bit v, input bit f);
        return 32'({TB_PSW'(e), 4'(b), ba, st, de, pa, sp, v, f});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.RX_IN   = 1'b1;
        bus.Par_Err = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.Sampled_bit = 1'($urandom);
            tick();
            check("idle", dut_vec(), 32'd0);
        end
    endtask

    // Cycle 0 is the current cycle, in which RX_IN is driven low; frame position p
    // counts clocks since the start bit began, so bit = p / P and edge = p % P.
    task automatic run_frame(input int P, input bit par, input logic [7:0] data,
                             input bit stop_b, input bit perr, input bit glitch,
                             input bit from_done, input int p_mid,
                             output int ev_cycle, output bit saw_dv, output bit saw_fe,
                             output int max_bit, output bit saw_par, output int deser_cnt);
        logic bits [0:DATA_W+2];
        int   stp_idx, n_bits, off, last_p, cyc, idx, e;
        stp_idx = par ? int'(PAR_IDX) + 1 : int'(PAR_IDX);
        n_bits  = stp_idx + 1;
        bits[0] = glitch;
        for (int i = 1; i <= int'(DATA_W); i++) bits[i] = data[i-1];
        bits[PAR_IDX]   = ^data;
        bits[stp_idx]   = stop_b;
        off       = from_done ? 1 : 0;
        last_p    = glitch ? P - 1 : n_bits * P - 1;
        cyc       = 0;
        max_bit   = 0;
        saw_par   = 1'b0;
        deser_cnt = 0;
        bus.RX_IN    = 1'b0;
        bus.Prescale = TB_PSW'(P);
        bus.PAR_EN   = par;
        bus.Par_Err  = perr;
        for (int p = off; p <= last_p; p++) begin
            tick();
            cyc++;
            idx = p / P;
            e   = p % P;
            check("frame_cycle", dut_vec(),
                  exp_vec(e, idx, e == P - 1, idx == 0,
                          idx >= 1 && idx <= int'(DATA_W), par && idx == int'(PAR_IDX),
                          idx == stp_idx, 1'b0, 1'b0));
            if (int'(bus.Bit_Cnt) > max_bit) max_bit = int'(bus.Bit_Cnt);
            saw_par   = saw_par | bus.Par_Chk_En;
            deser_cnt = deser_cnt + int'(bus.Deser_En);
            bus.Sampled_bit = bits[idx];
            bus.RX_IN       = (glitch && p == 0) ? 1'b0 : bits[idx];
            if (p == off && p_mid != 0) bus.Prescale = TB_PSW'(p_mid);
        end
        tick();
        cyc++;
        if (glitch) begin
            check("glitch_idle", dut_vec(), 32'd0);
        end else begin
            check("done_cycle", dut_vec(),
                  exp_vec(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                          stop_b && !(par && perr), !stop_b));
        end
        ev_cycle = cyc;
        saw_dv   = bus.Data_Valid;
        saw_fe   = bus.Frame_Err;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit prev_b2b, gl, nb, par, stp, pe;
        int pr;
        logic [7:0] d;

        tbl[0] = '{8,  1'b1, 8'hA5, 1'b1, 1'b0, 89,  1'b1, 1'b0, 10, 1'b1};
        tbl[1] = '{16, 1'b0, 8'h3C, 1'b1, 1'b0, 161, 1'b1, 1'b0, 9,  1'b0};
        tbl[2] = '{8,  1'b1, 8'h96, 1'b0, 1'b0, 89,  1'b0, 1'b1, 10, 1'b1};
        tbl[3] = '{8,  1'b1, 8'h0F, 1'b1, 1'b1, 89,  1'b0, 1'b0, 10, 1'b1};
        tbl[4] = '{32, 1'b0, 8'hFF, 1'b1, 1'b0, 321, 1'b1, 1'b0, 9,  1'b0};
        tbl[5] = '{8,  1'b0, 8'h00, 1'b0, 1'b1, 81,  1'b0, 1'b1, 9,  1'b0};
        tbl[6] = '{8,  1'b0, 8'h55, 1'b1, 1'b1, 81,  1'b1, 1'b0, 9,  1'b0};
        tbl[7] = '{4,  1'b0, 8'hC3, 1'b1, 1'b0, 41,  1'b1, 1'b0, 9,  1'b0};

        rst             = 1'b1;
        bus.RX_IN       = 1'b1;
        bus.PAR_EN      = 1'b0;
        bus.Prescale    = TB_PSW'(8);
        bus.Sampled_bit = 1'b0;
        bus.Par_Err     = 1'b0;
        tick();
        tick();
        check("reset_state", dut_vec(), 32'd0);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < int'(N_VEC); i++) begin
            idle(2);
            run_frame(tbl[i].prescale, tbl[i].par_en, tbl[i].data, tbl[i].stop_b,
                      tbl[i].perr, 1'b0, 1'b0, 0, ev, dv, fe, mb, pw, dc);
            check($sformatf("vec%0d_event_cycle", i), 32'(ev), 32'(tbl[i].exp_cycle));
            check($sformatf("vec%0d_data_valid", i), 32'(dv), 32'(tbl[i].exp_dv));
            check($sformatf("vec%0d_frame_err", i), 32'(fe), 32'(tbl[i].exp_fe));
            check($sformatf("vec%0d_max_bit", i), 32'(mb), 32'(tbl[i].exp_max_bit));
            check($sformatf("vec%0d_par_window", i), 32'(pw), 32'(tbl[i].exp_par_win));
        end

        // Start glitch: back to IDLE at cycle 9, no data window, no pulse.
        idle(2);
        run_frame(8, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 0, ev, dv, fe, mb, pw, dc);
        check("glitch_cycle", 32'(ev), 32'd9);
        check("glitch_no_deser", 32'(dc), 32'd0);
        check("glitch_no_dv", 32'(dv), 32'd0);

        // Back-to-back frames: pulses 88 clocks apart.
        idle(2);
        run_frame(8, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 0, ev, dv, fe, mb, pw, dc);
        check("b2b_first_dv", 32'(dv), 32'd1);
        run_frame(8, 1'b1, 8'hE1, 1'b1, 1'b0, 1'b0, 1'b1, 0, ev2, dv, fe, mb, pw, dc);
        check("b2b_gap", 32'(ev2), 32'd88);
        check("b2b_second_dv", 32'(dv), 32'd1);

        // Prescale changed mid-frame is ignored; the next frame picks it up.
        idle(2);
        run_frame(8, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 32, ev, dv, fe, mb, pw, dc);
        check("pmid_cycle", 32'(ev), 32'd81);
        idle(2);
        run_frame(32, 1'b0, 8'h18, 1'b1, 1'b0, 1'b0, 1'b0, 0, ev, dv, fe, mb, pw, dc);
        check("pmid_next_cycle", 32'(ev), 32'd321);

        // Asynchronous reset mid-DATA at Bit_Cnt 4.
        idle(2);
        bus.Prescale    = TB_PSW'(8);
        bus.PAR_EN      = 1'b1;
        bus.RX_IN       = 1'b0;
        bus.Sampled_bit = 1'b0;
        for (int i = 0; i < 33; i++) tick();
        check("pre_rst_state", dut_vec(), exp_vec(0, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        #2 rst = 1'b1;
        #1 check("async_rst", dut_vec(), 32'd0);
        bus.RX_IN = 1'b1;
        tick();
        rst = 1'b0;
        idle(3);

        // Prescale below the minimum never leaves IDLE.
        bus.Prescale = TB_PSW'(2);
        bus.RX_IN    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("prescale2_idle", dut_vec(), 32'd0);
        end
        bus.Prescale = TB_PSW'(3);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("prescale3_idle", dut_vec(), 32'd0);
        end
        idle(2);

        // Random frames against the timeline model.
        prev_b2b = 1'b0;
        for (int k = 0; k < 30; k++) begin
            pr  = 8 << $urandom_range(0, 2);
            par = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            stp = ($urandom_range(0, 3) != 0);
            pe  = 1'($urandom_range(0, 1));
            gl  = ($urandom_range(0, 7) == 0);
            nb  = !gl && ($urandom_range(0, 2) == 0) && (k != 29);
            if (!prev_b2b) idle(int'($urandom_range(1, 4)));
            run_frame(pr, par, d, stp, pe, gl, prev_b2b, 0, ev, dv, fe, mb, pw, dc);
            prev_b2b = nb;
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
